// File: rtl/gray_seq_stepper_if.sv
// Handshake/data bundle between the position stepper and its controller/consumer.
// Master drives control and ready; slave (the stepper) drives position and status.
interface gray_seq_stepper_if;
    logic       start;
    logic       stop;
    logic       dir;
    logic       load;
    logic [2:0] load_val;
    logic       ready;
    logic [2:0] A;
    logic       step_valid;
    logic       wrap;
    logic       busy;

    modport master (
        output start, stop, dir, load, load_val, ready,
        input  A, step_valid, wrap, busy
    );

    modport slave (
        input  start, stop, dir, load, load_val, ready,
        output A, step_valid, wrap, busy
    );
endinterface

// File: rtl/gray_seq_stepper.sv
// Prescaled 3-bit up/down position stepper feeding the encoder A input; SEQ_WRAP_STOP_EN makes a wrap end the sweep.
// Latency: first step PRESCALE edges after start is sampled; A/step_valid/wrap are registered, busy decodes state.
// Backpressure: a due step with ready low parks in WAIT holding A and pcnt until ready returns.
module gray_seq_stepper #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic                clk,
    input  logic                rst,
    gray_seq_stepper_if.slave   sif
);

    localparam int unsigned PW = $clog2(PRESCALE + 1);
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] pcnt, pcnt_nxt;
    logic [2:0]    a_q, a_step;
    logic          step_valid_q, wrap_q;
    logic          do_step;
    logic          step_wrap;

    assign a_step    = sif.dir ? (a_q + 3'd1) : (a_q - 3'd1);
    assign step_wrap = sif.dir ? (a_q == 3'd7) : (a_q == 3'd0);

    always_comb begin
        state_nxt = state;
        pcnt_nxt  = pcnt;
        do_step   = 1'b0;

        unique case (state)
            IDLE: begin
                pcnt_nxt = '0;
                if (sif.start && !sif.stop) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (pcnt == PMAX) begin
                    if (sif.ready) begin
                        do_step  = 1'b1;
                        pcnt_nxt = '0;
                    end else begin
                        state_nxt = WAIT;
                    end
                end else begin
                    pcnt_nxt = pcnt + PW'(1);
                end
            end
            WAIT: begin
                if (sif.ready) begin
                    do_step   = 1'b1;
                    pcnt_nxt  = '0;
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = IDLE;
                pcnt_nxt  = '0;
            end
        endcase

        // Stop outranks a due step; load outranks both but leaves state alone.
        if (state != IDLE && sif.stop) begin
            state_nxt = IDLE;
            pcnt_nxt  = '0;
            do_step   = 1'b0;
        end

        if (sif.load) begin
            do_step  = 1'b0;
            pcnt_nxt = '0;
            if (state != IDLE) begin
                state_nxt = sif.stop ? IDLE : state;
            end
        end

`ifdef SEQ_WRAP_STOP_EN
        if (do_step && step_wrap) begin
            state_nxt = IDLE;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            pcnt         <= '0;
            a_q          <= 3'd0;
            step_valid_q <= 1'b0;
            wrap_q       <= 1'b0;
        end else begin
            state        <= state_nxt;
            pcnt         <= pcnt_nxt;
            step_valid_q <= do_step;
            wrap_q       <= do_step && step_wrap;
            if (sif.load) begin
                a_q <= sif.load_val;
            end else if (do_step) begin
                a_q <= a_step;
            end
        end
    end

    assign sif.A          = a_q;
    assign sif.step_valid = step_valid_q;
    assign sif.wrap       = wrap_q;
    assign sif.busy       = (state != IDLE);

endmodule

// File: tb/tb_gray_seq_stepper.sv
// Directed bench for gray_seq_stepper (PRESCALE=4); expected steps are queued with their edge number
// and a negedge monitor checks every step_valid pulse against the queue.
module tb_gray_seq_stepper;

    logic clk;
    logic rst;
    int   cyc;
    int   tests;
    int   fails;

    typedef struct {
        int         cyc;
        logic [2:0] a;
        logic       w;
    } exp_t;

    exp_t exp_q[$];

    gray_seq_stepper_if sif ();

    gray_seq_stepper #(.PRESCALE(4)) dut (
        .clk (clk),
        .rst (rst),
        .sif (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push(input int c, input logic [2:0] a, input logic w);
        exp_t e;
        e.cyc = c;
        e.a   = a;
        e.w   = w;
        exp_q.push_back(e);
    endtask

    // Monitor: every step_valid must match the next queued step exactly.
    always @(negedge clk) begin
        if (sif.step_valid === 1'b1) begin
            exp_t e;
            tests = tests + 1;
            if (exp_q.size() == 0) begin
                fails = fails + 1;
                $display("FAIL step_unexpected: got A=%0d wrap=%0d at edge %0d, expected no step",
                         sif.A, sif.wrap, cyc);
            end else begin
                e = exp_q.pop_front();
                if (cyc != e.cyc || sif.A !== e.a || sif.wrap !== e.w) begin
                    fails = fails + 1;
                    $display("FAIL step: got edge=%0d A=%0d wrap=%0d, expected edge=%0d A=%0d wrap=%0d",
                             cyc, sif.A, sif.wrap, e.cyc, e.a, e.w);
                end
            end
        end
    end

    initial begin
        int n0;
        int n1;
        tests = 0;
        fails = 0;
        sif.start    = 1'b0;
        sif.stop     = 1'b0;
        sif.dir      = 1'b1;
        sif.load     = 1'b0;
        sif.load_val = 3'd0;
        sif.ready    = 1'b1;
        rst          = 1'b0;
        #1 rst = 1'b1;
        #2;
        check("reset_A", sif.A, 0);
        check("reset_busy", sif.busy, 0);
        check("reset_step_valid", sif.step_valid, 0);
        check("reset_wrap", sif.wrap, 0);
        tick();
        rst = 1'b0;
        ticks(2);
        check("idle_busy", sif.busy, 0);

        // Free run up through a wrap
        sif.dir   = 1'b1;
        sif.start = 1'b1;
        tick();
        n0 = cyc;
        sif.start = 1'b0;
        check("run_busy", sif.busy, 1);
        for (int k = 1; k <= 8; k++) push(n0 + 4 * k, 3'(k % 8), (k == 8));
        ticks(32);
        check("wrap_A", sif.A, 0);
`ifdef SEQ_WRAP_STOP_EN
        check("wrap_busy", sif.busy, 0);
`else
        check("wrap_busy", sif.busy, 1);
`endif
        sif.stop = 1'b1;
        tick();
        sif.stop = 1'b0;
        check("stop_busy", sif.busy, 0);

        // Down from 0 wraps to 7, then 6
        sif.dir   = 1'b0;
        sif.start = 1'b1;
        tick();
        n0 = cyc;
        sif.start = 1'b0;
        push(n0 + 4, 3'd7, 1'b1);
`ifdef SEQ_WRAP_STOP_EN
        ticks(4);
        check("down_oneshot_busy", sif.busy, 0);
        sif.start = 1'b1;
        tick();
        n1 = cyc;
        sif.start = 1'b0;
        push(n1 + 4, 3'd6, 1'b0);
        ticks(4);
`else
        n1 = n0;
        push(n0 + 8, 3'd6, 1'b0);
        ticks(8);
`endif
        check("down_A", sif.A, 6);
        sif.stop = 1'b1;
        tick();
        sif.stop = 1'b0;

        // Ready stall, then load and stop collisions
        sif.dir   = 1'b0;
        sif.ready = 1'b1;
        sif.start = 1'b1;
        tick();
        n0 = cyc;
        sif.start = 1'b0;
        push(n0 + 4, 3'd5, 1'b0);
        ticks(4);
        sif.ready = 1'b0;
        ticks(14);
        check("stall_A", sif.A, 5);
        check("stall_busy", sif.busy, 1);
        push(n0 + 19, 3'd4, 1'b0);
        push(n0 + 23, 3'd3, 1'b0);
        sif.ready = 1'b1;
        ticks(5);
        check("resume_A", sif.A, 3);
        ticks(3);
        sif.load     = 1'b1;
        sif.load_val = 3'd5;
        sif.dir      = 1'b1;
        push(n0 + 31, 3'd6, 1'b0);
        tick();
        sif.load = 1'b0;
        check("load_A", sif.A, 5);
        check("load_step_valid", sif.step_valid, 0);
        ticks(7);
        sif.stop = 1'b1;
        tick();
        sif.stop = 1'b0;
        check("stopcol_A", sif.A, 6);
        check("stopcol_busy", sif.busy, 0);
        sif.start = 1'b1;
        sif.stop  = 1'b1;
        tick();
        sif.start = 1'b0;
        sif.stop  = 1'b0;
        check("startstop_busy", sif.busy, 0);
        ticks(6);
        check("startstop_A", sif.A, 6);

        // Load with start in IDLE, then async reset mid-run
        sif.load_val = 3'd2;
        sif.load     = 1'b1;
        sif.start    = 1'b1;
        tick();
        n0 = cyc;
        sif.load  = 1'b0;
        sif.start = 1'b0;
        check("loadstart_A", sif.A, 2);
        check("loadstart_busy", sif.busy, 1);
        push(n0 + 4, 3'd3, 1'b0);
        ticks(5);
        check("prerst_A", sif.A, 3);
        #2 rst = 1'b1;
        #1;
        check("arst_A", sif.A, 0);
        check("arst_busy", sif.busy, 0);
        check("arst_step_valid", sif.step_valid, 0);
        tick();
        rst = 1'b0;
        ticks(10);
        check("postrst_A", sif.A, 0);
        check("postrst_busy", sif.busy, 0);
        check("pending_steps", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gray_seq_stepper.md
# gray_seq_stepper

Sequential position stepper that generates the 3-bit code index driven into the gray/one-hot encoder stage `A` input. It advances a 3-bit position up or down at a prescaled rate, gated by a ready handshake from the consumer. It supports synchronous load, start/stop control, and wrap detection, and sits directly upstream of `gray_hot_encoder`.

## Interface
- `PRESCALE`, default 4: clock cycles per step; legal range 1..255.
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: begin stepping; sampled only in IDLE.
- `stop`  in  1: abort stepping; return to IDLE.
- `dir`  in  1: 1 = up (+1), 0 = down (-1); sampled at each step edge.
- `load`  in  1: synchronous load of the position.
- `load_val`  in  3: value for load.
- `ready`  in  1: consumer can accept a new position.
- `A`  out  3: registered position; connects to the encoder `A`.
- `step_valid`  out  1: one-cycle pulse, high in the cycle `A` holds a newly stepped value.
- `wrap`  out  1: one-cycle pulse coincident with `step_valid` when the step wrapped.
- `busy`  out  1: high in RUN or WAIT.

## Operation
- State machine: IDLE, RUN, WAIT. Prescaler `pcnt` is `$clog2(PRESCALE+1)` bits wide.
- **IDLE:**
  - `busy` = 0 and `pcnt` held at 0.
  - `start` = 1 and `stop` = 0 go to RUN with `pcnt` = 0.
  - `start` and `stop` together keep the block in IDLE.
- **RUN:**
  - While `pcnt` < `PRESCALE`-1, `pcnt` increments.
  - When `pcnt` == `PRESCALE`-1 a step is due.
  - Step due with `ready` = 1: step, `pcnt` returns to 0, stay in RUN.
  - Step due with `ready` = 0: go to WAIT with `pcnt` held.
- **WAIT:** `ready` = 1 causes a step, `pcnt` returns to 0, go to RUN. No step or count change occurs while `ready` = 0.
- **Step:**
  - Up: `A` <= `A`+1, mod 8. Down: `A` <= `A`-1, mod 8.
  - `step_valid` = 1 on the next cycle.
  - `wrap` = 1 on up 7→0 or down 0→7.
- **Priority, highest first: `rst` > `load` > `stop` > step.**
  - `load` in any state: `A` <= `load_val` and `pcnt` <= 0. No `step_valid` or `wrap`. State is unchanged unless `stop` is also high.
  - `stop` in RUN or WAIT: go to IDLE next edge. A step due in the same cycle is suppressed.
  - `load` and `stop` in the same cycle: both take effect.
  - `load` and `start` in IDLE in the same cycle: both take effect.
- **Outputs:**
  - `A`, `step_valid`, and `wrap` are flops.
  - `busy` is decoded from the state register.
- **Reset values:** `A` = 0, state = IDLE, `pcnt` = 0, `step_valid` = 0, `wrap` = 0, `busy` = 0.

## Timing
- `start` sampled at edge e0: first step at edge e0+`PRESCALE` when `ready` stays high. New `A`, `step_valid`, and `wrap` are visible after that edge.
- Steady state with `ready` = 1: one step every `PRESCALE` cycles.
- `PRESCALE` = 1: a step is due every cycle, so there is one step per edge from e0+1.
- Stall in WAIT: the step occurs on the first edge where `ready` = 1. The next step follows `PRESCALE` edges later.
- `step_valid` and `wrap` last exactly one cycle. They never assert on load or reset.
- `rst` asserted mid-operation clears all outputs immediately, without waiting for a clock edge. The first edge after deassertion samples inputs normally.

## Configuration
- Macro `SEQ_WRAP_STOP_EN`.
- **Defined:** a step that asserts `wrap` also moves the state to IDLE on the same edge. The result is a one-shot sweep. `busy` falls in the same cycle `wrap` is seen.
- **Undefined:** stepping continues indefinitely across wraps until `stop`.

## Test plan
- **Free run, up.** `PRESCALE`=4, `rst` pulse, `dir`=1, `ready`=1, `start` at e0:
  - `A` = 1 after e4, 2 after e8, and so on.
  - 7→0 after e32 with `step_valid` = 1 and `wrap` = 1 for one cycle.
  - Undefined macro: `busy` stays 1.
  - Defined macro: `busy` = 0 after e32.
- **Down from 0.** `dir`=0, `start`: first step gives `A` = 7 with `wrap` = 1. The next step gives `A` = 6 with `wrap` = 0.
- **Ready stall.** `ready`=0 when the step is due:
  - `A` holds, `busy` = 1, no `step_valid` for 10 cycles.
  - Raise `ready`: step on the next edge, then the next step 4 edges later.
- **Load collision.** `load`=1, `load_val`=5 in the cycle a step is due: `A` = 5, `step_valid` = 0, next step 4 edges later to 6.
- **Stop collision.** `stop` in the cycle a step is due: `A` unchanged, no `step_valid`, `busy` = 0 next cycle. `start`+`stop` together in IDLE: `busy` stays 0.
- **Async reset.** Assert `rst` mid-RUN with `A` = 3 between clock edges: `A` = 0, `busy` = 0, and `step_valid` = 0 before the next edge. After release, no stepping until `start`.
